// File: rtl/audioplay_audio_pkg.sv
// Shared audio constants and types for the I2S playback path.
// Provides default slot/frame/divider sizes, the PCM sample type and a
// counter-width helper used by the transmitter.
package audioplay_audio_pkg;

  localparam int unsigned DEF_DATA_W     = 24;
  localparam int unsigned DEF_SLOT_W     = 32;
  localparam int unsigned DEF_FRAME_BITS = 2 * DEF_SLOT_W;
  localparam int unsigned DEF_MCLK_DIV   = 4;

  // One channel of two's complement PCM.
  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  // Stereo pair as it travels from the sample FIFO.
  typedef struct packed {
    sample_t left;
    sample_t right;
  } sample_pair_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audioplay_i2s_tx_if.sv
// Sample handshake between the playback FIFO (master) and the I2S
// transmitter (slave).
//   in_valid  master->slave  stereo pair valid
//   in_ready  slave->master  transmitter can accept a pair
//   in_left   master->slave  left sample, two's complement
//   in_right  master->slave  right sample, two's complement
interface audioplay_i2s_tx_if
  import audioplay_audio_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/audioplay_sync2.sv
// Two-flop synchronizer for a level signal crossing into clk.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset, output resets to 0
//   d      in  asynchronous level
//   q      out synchronized level
module audioplay_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/audioplay_i2s_tx.sv
// I2S master transmitter. Divides clk into BCLK, frames two SLOT_W-bit
// slots per LRCK period and shifts stereo PCM out MSB-first with the
// standard one-BCLK delay after each LRCK edge.
//   clk         in   audio clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag (asynchronous), gates the whole block
//   in_if       slave sample handshake (valid/ready, left/right)
//   i2s_bclk    out  bit clock
//   i2s_lrck    out  word select, 0 = left, 1 = right
//   i2s_sdata   out  serial data
//   underrun    out  one-cycle pulse when a frame loads with no sample
module audioplay_i2s_tx
  import audioplay_audio_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SLOT_W   = DEF_SLOT_W,
  parameter int unsigned MCLK_DIV = DEF_MCLK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  audioplay_i2s_tx_if.slave  in_if,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_sdata,
  output logic               underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned DIV_W      = cnt_width(MCLK_DIV);
  localparam int unsigned BIT_W      = cnt_width(FRAME_BITS);
  localparam int unsigned HALF_DIV   = MCLK_DIV / 2;

  logic                  en;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_W-1:0]     buf_left_q, buf_left_d;
  logic [DATA_W-1:0]     buf_right_q, buf_right_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  bclk_q, bclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;

  logic                  in_ready_c;
  logic                  accept_c;
  logic                  fall_evt_c;
  logic                  load_evt_c;
  logic [FRAME_BITS-1:0] frame_c;

  // Lock flag into the clk domain; everything idles while it is low.
  audioplay_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (en)
  );

  // Ready depends only on registers so the source sees no comb loop.
  assign in_ready_c = en & ~buf_full_q;
  assign accept_c   = in_if.in_valid & in_ready_c;
  assign fall_evt_c = en & (div_cnt_q == DIV_W'(MCLK_DIV - 1));
  // The load lands one BCLK after the LRCK fall, giving the I2S 1-bit delay.
  assign load_evt_c = fall_evt_c & (bit_cnt_q == '0);

  // Left slot in the upper half, right slot in the lower half, both
  // MSB-justified with zero padding below.
  assign frame_c = (FRAME_BITS'(buf_left_q)  << (FRAME_BITS - DATA_W)) |
                   (FRAME_BITS'(buf_right_q) << (SLOT_W - DATA_W));

  // Next-state for divider, framing, holding buffer and pin registers.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    buf_full_d  = buf_full_q;
    buf_left_d  = buf_left_q;
    buf_right_d = buf_right_q;
    shift_d     = shift_q;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;

    if (!en) begin
      // Losing lock abandons the frame; re-lock starts from bit 0.
      div_cnt_d   = '0;
      bit_cnt_d   = '0;
      buf_full_d  = 1'b0;
      buf_left_d  = '0;
      buf_right_d = '0;
      shift_d     = '0;
      bclk_d      = 1'b0;
      lrck_d      = 1'b0;
      sdata_d     = 1'b0;
    end else begin
      div_cnt_d = fall_evt_c ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d    = (div_cnt_d >= DIV_W'(HALF_DIV));

      if (accept_c) begin
        buf_full_d  = 1'b1;
        buf_left_d  = in_if.in_left;
        buf_right_d = in_if.in_right;
      end

      if (fall_evt_c) begin
        bit_cnt_d = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
        lrck_d    = (bit_cnt_d >= BIT_W'(SLOT_W));

        if (load_evt_c) begin
          shift_d    = buf_full_q ? frame_c : '0;
          underrun_d = ~buf_full_q;
          // An accept on this edge only happens when empty, so it survives.
          if (buf_full_q) begin
            buf_full_d = 1'b0;
          end
        end else begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end

        sdata_d = shift_d[FRAME_BITS-1];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      shift_q     <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      buf_full_q  <= buf_full_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      shift_q     <= shift_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign i2s_bclk       = bclk_q;
  assign i2s_lrck       = lrck_q;
  assign i2s_sdata      = sdata_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_audioplay_i2s_tx.sv
// Bench for audioplay_i2s_tx at default parameters (24-bit samples,
// 32-bit slots, clk/4 BCLK).
module tb_audioplay_i2s_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic i2s_bclk, i2s_lrck, i2s_sdata, underrun;

  audioplay_i2s_tx_if #(.DATA_W(24)) in_if ();

  audioplay_i2s_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .in_if      (in_if),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .underrun   (underrun)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in clk cycles since the synchronized lock went high;
  // BCLK bit b = cycles/4, frame bit = b mod 64, frame k loads at bit 64k+1.
  bit          m_s1 = 0, m_en = 0, m_full = 0, m_acc = 0;
  int          m_c = 0, m_b = 0;
  logic [23:0] m_l = '0, m_r = '0;
  logic [63:0] m_frame = '0;
  bit          e_bclk = 0, e_lrck = 0, e_sdata = 0, e_under = 0, e_ready = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 0; m_en = 0; m_full = 0; m_c = 0; m_frame = '0;
      e_bclk = 0; e_lrck = 0; e_sdata = 0; e_under = 0; e_ready = 0;
    end else begin
      m_acc = in_if.in_valid && m_en && !m_full;
      if (m_en) begin
        m_c     = m_c + 1;
        m_b     = (m_c / 4) % 64;
        e_bclk  = (m_c % 4) >= 2;
        e_lrck  = m_b >= 32;
        e_under = 0;
        if (m_c % 256 == 4) begin
          m_frame = m_full ? {m_l, 8'h00, m_r, 8'h00} : 64'h0;
          e_under = !m_full;
          m_full  = 0;
        end
        e_sdata = m_frame[63 - ((m_b + 63) % 64)];
        if (m_acc) begin
          m_full = 1; m_l = in_if.in_left; m_r = in_if.in_right;
        end
      end else begin
        m_c = 0; m_full = 0; m_frame = '0;
        e_bclk = 0; e_lrck = 0; e_sdata = 0; e_under = 0;
      end
      m_en    = m_s1;
      m_s1    = pll_locked;
      e_ready = m_en && !m_full;
    end
  end

  // Cycle-by-cycle comparison against the model.
  bit cmp_on = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("cyc_bclk",     64'(i2s_bclk),       64'(e_bclk));
      chk("cyc_lrck",     64'(i2s_lrck),       64'(e_lrck));
      chk("cyc_sdata",    64'(i2s_sdata),      64'(e_sdata));
      chk("cyc_underrun", 64'(underrun),       64'(e_under));
      chk("cyc_in_ready", 64'(in_if.in_ready), 64'(e_ready));
    end
  end

  // ---------------- directed helpers ----------------
  int cyc = 0, ur_cnt = 0, sd_ones = 0;
  bit pb = 0, pl = 0, rise_b = 0, rise_l = 0, fall_l = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (underrun)  ur_cnt++;
    if (i2s_sdata) sd_ones++;
    rise_b = i2s_bclk && !pb;
    rise_l = i2s_lrck && !pl;
    fall_l = !i2s_lrck && pl;
    pb = i2s_bclk;
    pl = i2s_lrck;
  endtask

  // kind: 0 bclk rise, 1 lrck rise, 2 lrck fall, 3 in_ready high
  task automatic wait_evt(input int kind, input string nm);
    bit hit = 0;
    for (int t = 0; t < 600 && !hit; t++) begin
      tick();
      case (kind)
        0:       hit = rise_b;
        1:       hit = rise_l;
        2:       hit = fall_l;
        default: hit = in_if.in_ready;
      endcase
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for event", nm);
    end
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input bit keep,
                           input string nm, output int acc_cyc);
    bit hit = 0;
    in_if.in_valid = 1'b1;
    in_if.in_left  = l;
    in_if.in_right = r;
    acc_cyc = -1;
    for (int t = 0; t < 600 && !hit; t++) begin
      if (in_if.in_ready) begin
        hit = 1;
        acc_cyc = cyc;
      end
      tick();
    end
    if (!keep) in_if.in_valid = 1'b0;
    if (!hit) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for in_ready", nm);
    end else begin
      chk({nm, "_ready_drop"}, 64'(in_if.in_ready), 64'(0));
    end
  endtask

  function automatic logic [63:0] pins();
    return 64'({i2s_bclk, i2s_lrck, i2s_sdata, underrun, in_if.in_ready});
  endfunction

  logic [23:0] sl [4] = '{24'h800001, 24'h7FFFFF, 24'h00F00F, 24'hC3C3C3};
  logic [23:0] sr [4] = '{24'h123123, 24'hFEDCBA, 24'h000001, 24'h3C3C3C};

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          c0, hi, dummy;
    int          acc [4];
    bit          done;
    bit          bits [65];
    logic [23:0] lcap, rcap;
    logic [7:0]  lpad, rpad;

    in_if.in_valid = 1'b0;
    in_if.in_left  = '0;
    in_if.in_right = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1;

    // Reset / unlocked idle.
    repeat (4) tick();
    chk("reset_idle", pins(), 64'(0));

    // Lock rises: ready after two synchronizer stages.
    pll_locked = 1'b1;
    tick();
    chk("ready_after_1clk", 64'(in_if.in_ready), 64'(0));
    tick();
    chk("ready_by_3rd_clk", 64'(in_if.in_ready), 64'(1));

    // BCLK shape.
    wait_evt(0, "bclk_rise");
    c0 = cyc; hi = 1; done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      tick();
      if (rise_b) done = 1;
      else if (i2s_bclk) hi++;
    end
    chk("bclk_period", 64'(cyc - c0), 64'(4));
    chk("bclk_high",   64'(hi),       64'(2));

    // LRCK period.
    wait_evt(1, "lrck_rise_a");
    c0 = cyc;
    wait_evt(1, "lrck_rise_b");
    chk("lrck_period", 64'(cyc - c0), 64'(256));

    // Starved: one underrun per frame, silent data.
    ur_cnt = 0; sd_ones = 0;
    repeat (768) tick();
    chk("idle_underruns", 64'(ur_cnt),  64'(3));
    chk("idle_sdata",     64'(sd_ones), 64'(0));

    // Single pair, captured on BCLK rising edges after the LRCK fall.
    wait_evt(1, "lrck_rise_c");
    send_pair(24'hABCDEF, 24'h123456, 0, "pair_a", dummy);
    wait_evt(2, "lrck_fall_a");
    for (int k = 0; k < 65; k++) begin
      wait_evt(0, "bclk_bit");
      bits[k] = i2s_sdata;
    end
    for (int i = 0; i < 24; i++) begin
      lcap[23-i] = bits[1+i];
      rcap[23-i] = bits[33+i];
    end
    for (int i = 0; i < 8; i++) begin
      lpad[7-i] = bits[25+i];
      rpad[7-i] = bits[57+i];
    end
    chk("left_data",  64'(lcap), 64'(24'hABCDEF));
    chk("left_pad",   64'(lpad), 64'(0));
    chk("right_data", 64'(rcap), 64'(24'h123456));
    chk("right_pad",  64'(rpad), 64'(0));

    // Back-to-back stream with in_valid held high.
    wait_evt(1, "lrck_rise_d");
    ur_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_pair(sl[i], sr[i], 1, "stream", acc[i]);
    end
    in_if.in_valid = 1'b0;
    chk("accept_gap_12", 64'(acc[2] - acc[1]), 64'(256));
    chk("accept_gap_23", 64'(acc[3] - acc[2]), 64'(256));
    wait_evt(2, "lrck_fall_s");
    repeat (8) tick();
    chk("stream_underruns", 64'(ur_cnt), 64'(0));

    // Lock drop at bit 40 with a pair buffered.
    wait_evt(1, "lrck_rise_e");
    send_pair(24'h5A5A5A, 24'hA5A5A5, 0, "pair_d", dummy);
    done = 0;
    for (int t = 0; t < 600 && !done; t++) begin
      if (((m_c / 4) % 64) == 40) done = 1;
      else tick();
    end
    chk("reach_bit40", 64'(done), 64'(1));
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("drop_idle", pins(), 64'(0));
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_evt(3, "relock");
    chk("relock_lrck_low", 64'(i2s_lrck), 64'(0));
    ur_cnt = 0;
    repeat (8) tick();
    chk("relock_underrun", 64'(ur_cnt), 64'(1));

    // Asynchronous reset mid-frame.
    wait_evt(1, "lrck_rise_f");
    send_pair(24'h0F0F0F, 24'hF0F0F0, 0, "pair_r", dummy);
    repeat (20) tick();
    #1 rst_n = 1'b0;
    #1 chk("async_reset", pins(), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    wait_evt(3, "restart");
    ur_cnt = 0;
    repeat (8) tick();
    chk("restart_underrun", 64'(ur_cnt), 64'(1));
    send_pair(24'h654321, 24'h9ABCDE, 0, "pair_z", dummy);
    repeat (600) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
